mac_accum4: RTL and testbench

- Four-lane signed multiply-accumulate stage sitting directly upstream of the four-lane ReLU stage.
- Each input beat carries one shared activation and four per-lane weights. The block accumulates NUM_TERMS products per lane with saturation.
- When the vector is complete it presents four ACC_SIZE-bit sums and a one-cycle acc_ready pulse. These drive the ReLU stage's in0..in3 and in_ready directly.

---
 rtl/mac_accum4_if.sv | 29 ++
 rtl/mac_accum4.sv | 110 +++++++++++
 tb/tb_mac_accum4.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_accum4_if.sv
// rtl/mac_accum4_if.sv - beat input / vector output bundle between the MAC stage and its neighbours
interface mac_accum4_if #(
    parameter int DATA_SIZE = 8,
    parameter int ACC_SIZE  = 21
);
    logic                        start;
    logic                        data_valid;
    logic signed [DATA_SIZE-1:0] x_in;
    logic signed [DATA_SIZE-1:0] w0;
    logic signed [DATA_SIZE-1:0] w1;
    logic signed [DATA_SIZE-1:0] w2;
    logic signed [DATA_SIZE-1:0] w3;
    logic                        busy;
    logic                        acc_ready;
    logic signed [ACC_SIZE-1:0]  out0;
    logic signed [ACC_SIZE-1:0]  out1;
    logic signed [ACC_SIZE-1:0]  out2;
    logic signed [ACC_SIZE-1:0]  out3;

    modport master (
        output start, data_valid, x_in, w0, w1, w2, w3,
        input  busy, acc_ready, out0, out1, out2, out3
    );

    modport slave (
        input  start, data_valid, x_in, w0, w1, w2, w3,
        output busy, acc_ready, out0, out1, out2, out3
    );
endinterface

// File: rtl/mac_accum4.sv
// rtl/mac_accum4.sv - four-lane signed saturating multiply-accumulate feeding the ReLU stage
module mac_accum4 #(
    parameter int DATA_SIZE = 8,
    parameter int ACC_SIZE  = 21,
    parameter int NUM_TERMS = 16,
    parameter int CNT_SIZE  = 7
) (
    input logic         clk,
    input logic         rst_n,
    mac_accum4_if.slave bus
);
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    localparam logic signed [ACC_SIZE-1:0] ACC_MAX   = {1'b0, {(ACC_SIZE-1){1'b1}}};
    localparam logic signed [ACC_SIZE-1:0] ACC_MIN   = {1'b1, {(ACC_SIZE-1){1'b0}}};
    localparam logic [CNT_SIZE-1:0]        LAST_BEAT = CNT_SIZE'(NUM_TERMS - 1);

    state_t                     r_state;
    logic [CNT_SIZE-1:0]        r_cnt;
    logic                       r_busy;
    logic                       r_ready;
    logic signed [ACC_SIZE-1:0] r_acc [4];
    logic signed [ACC_SIZE-1:0] r_out [4];

    logic signed [DATA_SIZE-1:0] w_wt  [4];
    logic signed [ACC_SIZE-1:0]  w_sum [4];

    // One guard bit above the accumulator is enough to detect overflow of acc + product.
    function automatic logic signed [ACC_SIZE-1:0] sat_mac(
        input logic signed [ACC_SIZE-1:0]  acc,
        input logic signed [DATA_SIZE-1:0] x,
        input logic signed [DATA_SIZE-1:0] w
    );
        logic signed [2*DATA_SIZE-1:0] prod;
        logic signed [ACC_SIZE:0]      sum;
        prod = (2*DATA_SIZE)'(x) * (2*DATA_SIZE)'(w);
        sum  = (ACC_SIZE+1)'(acc) + (ACC_SIZE+1)'(prod);
        if (sum[ACC_SIZE] != sum[ACC_SIZE-1]) begin
            return sum[ACC_SIZE] ? ACC_MIN : ACC_MAX;
        end
        return sum[ACC_SIZE-1:0];
    endfunction

    always_comb begin
        w_wt[0] = bus.w0;
        w_wt[1] = bus.w1;
        w_wt[2] = bus.w2;
        w_wt[3] = bus.w3;
        for (int i = 0; i < 4; i++) begin
            w_sum[i] = sat_mac(r_acc[i], bus.x_in, w_wt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_acc[i] <= '0;
                r_out[i] <= '0;
            end
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_ACCUM;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        for (int i = 0; i < 4; i++) begin
                            r_acc[i] <= '0;
                        end
                    end
                end
                S_ACCUM: begin
                    if (bus.data_valid) begin
                        // The final beat goes straight to the outputs so acc_ready follows it by one cycle.
                        if (r_cnt == LAST_BEAT) begin
                            for (int i = 0; i < 4; i++) begin
                                r_out[i] <= w_sum[i];
                            end
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            for (int i = 0; i < 4; i++) begin
                                r_acc[i] <= w_sum[i];
                            end
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.acc_ready = r_ready;
    assign bus.out0      = r_out[0];
    assign bus.out1      = r_out[1];
    assign bus.out2      = r_out[2];
    assign bus.out3      = r_out[3];
endmodule

// File: tb/tb_mac_accum4.sv
// tb/tb_mac_accum4.sv - scoreboard bench for mac_accum4 at NUM_TERMS=4 and NUM_TERMS=64
module tb_mac_accum4;
    localparam int DS   = 8;
    localparam int AS   = 21;
    localparam int AMAX = (1 << (AS - 1)) - 1;
    localparam int AMIN = -(1 << (AS - 1));

    typedef struct {
        int x;
        int w[4];
    } beat_t;

    typedef struct {
        int o[4];
        int cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rst_q = 1'b1;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= !rst_n;
    end

    mac_accum4_if #(.DATA_SIZE(DS), .ACC_SIZE(AS)) if4  ();
    mac_accum4_if #(.DATA_SIZE(DS), .ACC_SIZE(AS)) if64 ();

    mac_accum4 #(.DATA_SIZE(DS), .ACC_SIZE(AS), .NUM_TERMS(4), .CNT_SIZE(7)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4)
    );
    mac_accum4 #(.DATA_SIZE(DS), .ACC_SIZE(AS), .NUM_TERMS(64), .CNT_SIZE(7)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .bus(if64)
    );

    logic                 st  [2];
    logic                 dv  [2];
    logic signed [DS-1:0] xi  [2];
    logic signed [DS-1:0] wi  [2][4];
    logic signed [AS-1:0] mo  [2][4];
    logic                 rdy [2];
    logic                 bsy [2];

    assign if4.start = st[0];  assign if4.data_valid = dv[0];  assign if4.x_in = xi[0];
    assign if4.w0 = wi[0][0];  assign if4.w1 = wi[0][1];  assign if4.w2 = wi[0][2];  assign if4.w3 = wi[0][3];
    assign if64.start = st[1]; assign if64.data_valid = dv[1]; assign if64.x_in = xi[1];
    assign if64.w0 = wi[1][0]; assign if64.w1 = wi[1][1]; assign if64.w2 = wi[1][2]; assign if64.w3 = wi[1][3];
    assign mo[0][0] = if4.out0;  assign mo[0][1] = if4.out1;  assign mo[0][2] = if4.out2;  assign mo[0][3] = if4.out3;
    assign mo[1][0] = if64.out0; assign mo[1][1] = if64.out1; assign mo[1][2] = if64.out2; assign mo[1][3] = if64.out3;
    assign rdy[0] = if4.acc_ready;  assign bsy[0] = if4.busy;
    assign rdy[1] = if64.acc_ready; assign bsy[1] = if64.busy;

    exp_t q0[$];
    exp_t q1[$];
    int   held    [2][4];
    int   rc_last [2];
    int   rc_prev [2];

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > AMAX) return AMAX;
        if (v < AMIN) return AMIN;
        return v;
    endfunction

    function automatic beat_t mk(input int x, input int w0, input int w1, input int w2, input int w3);
        beat_t b;
        b.x = x; b.w[0] = w0; b.w[1] = w1; b.w[2] = w2; b.w[3] = w3;
        return b;
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(255)) - 128;
    endfunction

    task automatic set_in(input int s, input logic a_st, input logic a_dv, input int x,
                          input int w0, input int w1, input int w2, input int w3);
        st[s] = a_st; dv[s] = a_dv; xi[s] = DS'(x);
        wi[s][0] = DS'(w0); wi[s][1] = DS'(w1); wi[s][2] = DS'(w2); wi[s][3] = DS'(w3);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            set_in(s, 1'b0, 1'($urandom_range(1)), rnd8(), rnd8(), rnd8(), rnd8(), rnd8());
            step();
        end
    endtask

    // Drives start, then the beats (optionally with garbage stalls and stray start/valid),
    // and queues the arithmetic result the vector must produce.
    task automatic run_vector(input int s, input beat_t bt[$], input int stall_pct, input bit dv_with_start);
        exp_t e;
        int   acc[4];
        for (int l = 0; l < 4; l++) acc[l] = 0;
        set_in(s, 1'b1, dv_with_start, rnd8(), rnd8(), rnd8(), rnd8(), rnd8());
        step();
        check($sformatf("dut%0d_busy_after_start", s), bsy[s], 1);
        foreach (bt[i]) begin
            while (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) begin
                set_in(s, 1'($urandom_range(1)), 1'b0, rnd8(), rnd8(), rnd8(), rnd8(), rnd8());
                step();
            end
            set_in(s, (stall_pct > 0 && i != bt.size() - 1) ? 1'($urandom_range(1)) : 1'b0, 1'b1,
                   bt[i].x, bt[i].w[0], bt[i].w[1], bt[i].w[2], bt[i].w[3]);
            for (int l = 0; l < 4; l++) acc[l] = clamp(acc[l] + bt[i].x * bt[i].w[l]);
            if (i == bt.size() - 1) begin
                for (int l = 0; l < 4; l++) e.o[l] = acc[l];
                e.cyc = cyc + 1;
                if (s == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
            step();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   empty;
        for (int s = 0; s < 2; s++) begin
            if (rst_q) begin
                for (int l = 0; l < 4; l++) held[s][l] = 0;
            end
            if (rdy[s] === 1'b1) begin
                rc_prev[s] = rc_last[s];
                rc_last[s] = cyc;
                check($sformatf("dut%0d_busy_at_ready", s), bsy[s], 0);
                empty = (s == 0) ? (q0.size() == 0) : (q1.size() == 0);
                if (empty) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL dut%0d_unexpected_ready: acc_ready=1 required 0 (cycle %0d)", s, cyc);
                end else begin
                    e = (s == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("dut%0d_ready_cycle", s), cyc, e.cyc);
                    for (int l = 0; l < 4; l++) begin
                        check($sformatf("dut%0d_out%0d", s, l), mo[s][l], e.o[l]);
                        held[s][l] = e.o[l];
                    end
                end
            end else begin
                check($sformatf("dut%0d_ready_low", s), rdy[s], 0);
                for (int l = 0; l < 4; l++)
                    check($sformatf("dut%0d_out%0d_hold", s, l), mo[s][l], held[s][l]);
            end
        end
    end

    initial begin
        beat_t vb[$];
        int    sx;

        for (int s = 0; s < 2; s++) begin
            rc_last[s] = 0;
            rc_prev[s] = 0;
            set_in(s, 1'b1, 1'b1, rnd8(), rnd8(), rnd8(), rnd8(), rnd8());
        end

        // Reset held with start and data_valid asserted.
        for (int c = 0; c < 3; c++) begin
            step();
            for (int s = 0; s < 2; s++) begin
                check($sformatf("dut%0d_reset_busy", s), bsy[s], 0);
                check($sformatf("dut%0d_reset_ready", s), rdy[s], 0);
                check($sformatf("dut%0d_reset_out0", s), mo[s][0], 0);
            end
        end
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) set_in(s, 1'b0, 1'b1, rnd8(), rnd8(), rnd8(), rnd8(), rnd8());
        for (int c = 0; c < 4; c++) begin
            step();
            check("dut0_idle_busy", bsy[0], 0);
            check("dut1_idle_busy", bsy[1], 0);
        end

        // Basic vector.
        vb = {};
        for (int i = 0; i < 4; i++) vb.push_back(mk(3, 1, -2, 5, 0));
        run_vector(0, vb, 0, 1'b0);
        idle(0, 3);
        check("basic_ready_count", rc_last[0] > 0, 1);

        // Stalls, garbage, mid-vector start and a beat alongside start.
        run_vector(0, vb, 50, 1'b1);
        idle(0, 3);

        // Reset after two of four beats.
        set_in(0, 1'b1, 1'b0, 0, 0, 0, 0, 0);
        step();
        set_in(0, 1'b0, 1'b1, 7, 7, 7, 7, 7);
        step();
        set_in(0, 1'b0, 1'b1, 7, 7, 7, 7, 7);
        step();
        rst_n = 1'b0;
        set_in(0, 1'b0, 1'b1, 7, 7, 7, 7, 7);
        step();
        check("midreset_busy", bsy[0], 0);
        check("midreset_out0", mo[0][0], 0);
        check("midreset_out3", mo[0][3], 0);
        rst_n = 1'b1;
        idle(0, 3);
        vb = {};
        for (int i = 0; i < 4; i++) vb.push_back(mk(1, 1, 1, 1, 1));
        run_vector(0, vb, 0, 1'b0);
        idle(0, 2);

        // Back-to-back: second start lands in the first acc_ready cycle.
        vb = {};
        for (int i = 0; i < 4; i++) vb.push_back(mk(3, 1, -2, 5, 0));
        run_vector(0, vb, 0, 1'b0);
        vb = {};
        for (int i = 0; i < 4; i++) vb.push_back(mk(2, -1, -1, -1, -1));
        run_vector(0, vb, 0, 1'b0);
        idle(0, 2);
        check("b2b_ready_spacing", rc_last[0] - rc_prev[0], 5);

        // Randomised vectors on the 4-term instance, sometimes back-to-back.
        for (int v = 0; v < 20; v++) begin
            vb = {};
            for (int i = 0; i < 4; i++) vb.push_back(mk(rnd8(), rnd8(), rnd8(), rnd8(), rnd8()));
            run_vector(0, vb, 30, 1'($urandom_range(1)));
            idle(0, int'($urandom_range(2)));
        end
        idle(0, 2);

        // Saturation on the 64-term instance.
        vb = {};
        for (int i = 0; i < 64; i++) vb.push_back(mk(-128, -128, 127, 1, 0));
        run_vector(1, vb, 0, 1'b0);
        idle(1, 2);
        vb = {};
        for (int i = 0; i < 63; i++) vb.push_back(mk(-128, -128, 0, 0, 0));
        vb.push_back(mk(-128, 127, 0, 0, 0));
        run_vector(1, vb, 0, 1'b0);
        idle(1, 2);

        // Randomised large-magnitude vectors driving lanes towards the clamps.
        for (int v = 0; v < 5; v++) begin
            vb = {};
            sx = ($urandom_range(1) != 0) ? 127 : -128;
            for (int i = 0; i < 64; i++)
                vb.push_back(mk(sx, 127 - int'($urandom_range(10)), -128 + int'($urandom_range(10)),
                                rnd8(), ($urandom_range(3) == 0) ? -127 : 127));
            run_vector(1, vb, 10, 1'($urandom_range(1)));
            idle(1, int'($urandom_range(2)));
        end

        for (int i = 0; i < 20 && (q0.size() + q1.size()) > 0; i++) step();
        idle(0, 2);
        check("scoreboard_drained", q0.size() + q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
